// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU. Logic/arith/shift ops finish in one cycle;
//            unsigned multiply (and divide when SEQ_ALU_DIV_EN is defined)
//            iterate one bit per cycle behind a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    input  logic             set_flags,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C
);

    localparam int              c_cw       = $clog2(WIDTH + 1);
    localparam logic [c_cw-1:0] c_cnt_init = c_cw'(WIDTH);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [3:0] c_op_add   = 4'b0000;
    localparam logic [3:0] c_op_sub   = 4'b0001;
    localparam logic [3:0] c_op_and   = 4'b0010;
    localparam logic [3:0] c_op_or    = 4'b0011;
    localparam logic [3:0] c_op_xor   = 4'b0100;
    localparam logic [3:0] c_op_srl   = 4'b0101;
    localparam logic [3:0] c_op_sll   = 4'b0110;
    localparam logic [3:0] c_op_sra   = 4'b0111;
    localparam logic [3:0] c_op_mul   = 4'b1000;
    localparam logic [3:0] c_op_umulh = 4'b1001;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] c_op_udiv  = 4'b1010;
    localparam logic [3:0] c_op_urem  = 4'b1011;
`endif

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_z, r_n, r_v, r_c;
    logic               r_set_flags;
    logic               r_hi;
    logic [c_cw-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opa;

    logic               w_is_sub;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_sum;
    logic               w_add_v;
    logic [SW-1:0]      w_amt;
    logic [WIDTH:0]     w_srl_ext;
    logic [WIDTH:0]     w_sll_ext;
    logic signed [WIDTH:0] w_sra_ext;

    assign w_is_sub  = (ALUControl == c_op_sub);
    assign w_b_eff   = w_is_sub ? ~b : b;
    assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_add_v   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_amt     = b[SW-1:0];
    // One guard bit beside the operand captures the last bit shifted out
    assign w_srl_ext = {a, 1'b0} >> w_amt;
    assign w_sll_ext = {1'b0, a} << w_amt;
    assign w_sra_ext = $signed({a, 1'b0}) >>> w_amt;

    logic [WIDTH-1:0] w_res;
    logic             w_c_new;
    logic             w_v_new;
    logic             w_legal;
    logic             w_iter_op;

    always_comb begin
        w_res     = '0;
        w_c_new   = r_c;
        w_v_new   = r_v;
        w_legal   = 1'b1;
        w_iter_op = 1'b0;
        case (ALUControl)
            c_op_add, c_op_sub: begin
                w_res   = w_sum[WIDTH-1:0];
                w_c_new = w_sum[WIDTH];
                w_v_new = w_add_v;
            end
            c_op_and: w_res = a & b;
            c_op_or:  w_res = a | b;
            c_op_xor: w_res = a ^ b;
            c_op_srl: begin
                w_res = w_srl_ext[WIDTH:1];
                if (w_amt != '0) w_c_new = w_srl_ext[0];
            end
            c_op_sll: begin
                w_res = w_sll_ext[WIDTH-1:0];
                if (w_amt != '0) w_c_new = w_sll_ext[WIDTH];
            end
            c_op_sra: begin
                w_res = w_sra_ext[WIDTH:1];
                if (w_amt != '0) w_c_new = w_sra_ext[0];
            end
            c_op_mul, c_op_umulh: w_iter_op = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            c_op_udiv, c_op_urem: w_iter_op = 1'b1;
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // Shared 2N-bit accumulator: {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_acc_init;
    logic [WIDTH-1:0]   w_opa_init;
    logic [WIDTH-1:0]   w_iter_res;
    logic               w_div_zero;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);

`ifdef SEQ_ALU_DIV_EN
    logic             r_is_div;
    logic             w_start_div;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;

    assign w_start_div = (ALUControl == c_op_udiv) || (ALUControl == c_op_urem);
    assign w_div_sh    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_sh >= {1'b0, r_opa});
    assign w_div_diff  = w_div_sh[WIDTH-1:0] - r_opa;
    assign w_acc_next  = !r_is_div ? {w_mul_sum, r_acc[WIDTH-1:1]} :
                         w_div_ge  ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1} :
                                     {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    assign w_acc_init  = w_start_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
    assign w_opa_init  = w_start_div ? b : a;
    assign w_div_zero  = r_is_div && (r_opa == '0);
`else
    assign w_acc_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_acc_init  = {{WIDTH{1'b0}}, b};
    assign w_opa_init  = a;
    assign w_div_zero  = 1'b0;
`endif

    assign w_iter_res = r_hi ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_idle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_c         <= 1'b0;
            r_set_flags <= 1'b0;
            r_hi        <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opa       <= '0;
`ifdef SEQ_ALU_DIV_EN
            r_is_div    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_run: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - c_cnt_last;
                    if (r_cnt == c_cnt_last) begin
                        r_state  <= c_done;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_iter_res;
                        if (r_set_flags) begin
                            r_z <= (w_iter_res == '0);
                            r_n <= w_iter_res[WIDTH-1];
                            if (w_div_zero) r_v <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (r_state == c_done) r_state <= c_idle;
                    if (start) begin
                        if (w_iter_op) begin
                            r_state     <= c_run;
                            r_busy      <= 1'b1;
                            r_set_flags <= set_flags;
                            r_hi        <= ALUControl[0];
                            r_cnt       <= c_cnt_init;
                            r_acc       <= w_acc_init;
                            r_opa       <= w_opa_init;
`ifdef SEQ_ALU_DIV_EN
                            r_is_div    <= w_start_div;
`endif
                        end else begin
                            r_state  <= c_done;
                            r_done   <= 1'b1;
                            r_result <= w_res;
                            if (set_flags && w_legal) begin
                                r_z <= (w_res == '0);
                                r_n <= w_res[WIDTH-1];
                                r_c <= w_c_new;
                                r_v <= w_v_new;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign Z      = r_z;
    assign N      = r_n;
    assign V      = r_v;
    assign C      = r_c;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed self-checking bench for seq_alu at WIDTH=8; honours
//            SEQ_ALU_DIV_EN to pick the expected divide behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] alu_ctl;
    logic       set_flags;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       f_z, f_n, f_v, f_c;
    logic [3:0] flags;

    assign flags = {f_n, f_z, f_c, f_v};

    seq_alu #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (op_a),
        .b          (op_b),
        .ALUControl (alu_ctl),
        .set_flags  (set_flags),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .Z          (f_z),
        .N          (f_n),
        .V          (f_v),
        .C          (f_c)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Launch one op and wait (bounded) for done; optionally poke start/operands mid-run
    task automatic do_op(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                         input logic sf, input bit pulse, output int lat, output int bcnt);
        alu_ctl   = op;
        op_a      = ia;
        op_b      = ib;
        set_flags = sf;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (pulse && lat == 3) begin
                start     = 1'b1;
                alu_ctl   = 4'b0000;
                op_a      = 8'h11;
                op_b      = 8'h22;
                set_flags = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] ia,
                       input logic [7:0] ib, input logic sf, input bit pulse,
                       input logic [7:0] exp_res, input logic [3:0] exp_flags, input int exp_lat);
        int lat;
        int bcnt;
        do_op(op, ia, ib, sf, pulse, lat, bcnt);
        check({tag, "_lat"},   16'(lat),  16'(exp_lat));
        check({tag, "_busy"},  16'(bcnt), 16'(exp_lat));
        check({tag, "_res"},   {8'h00, result}, {8'h00, exp_res});
        check({tag, "_flags"}, {12'h000, flags}, {12'h000, exp_flags});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic late;
        reset     = 1'b1;
        start     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        alu_ctl   = '0;
        set_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {15'd0, busy}, 16'd0);
        check("rst_done",   {15'd0, done}, 16'd0);
        check("rst_result", {8'h00, result}, 16'h0000);
        check("rst_flags",  {12'h000, flags}, 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;

        // flags packed as {N,Z,C,V}
        run("add", 4'b0000, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 4'b1001, 0);
        @(posedge clk); #1;
        check("add_done_pulse", {15'd0, done}, 16'd0);
        check("add_hold", {8'h00, result}, 16'h0080);

        run("sub",    4'b0001, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 4'b0110, 0);
        run("and",    4'b0010, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'h00, 4'b0110, 0);
        run("subbrw", 4'b0001, 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 4'b1000, 0);
        run("or",     4'b0011, 8'h0C, 8'h30, 1'b1, 1'b0, 8'h3C, 4'b0000, 0);
        run("sub2",   4'b0001, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 4'b0110, 0);
        run("mul",    4'b1000, 8'd15, 8'd17, 1'b1, 1'b1, 8'hFF, 4'b1010, 8);
        run("umulh",  4'b1001, 8'd200, 8'd200, 1'b1, 1'b0, 8'h9C, 4'b1010, 8);
        run("sra",    4'b0111, 8'h90, 8'h03, 1'b1, 1'b0, 8'hF2, 4'b1000, 0);
        run("sll",    4'b0110, 8'h81, 8'h01, 1'b1, 1'b0, 8'h02, 4'b0010, 0);
        run("srl0",   4'b0101, 8'hA5, 8'h08, 1'b1, 1'b0, 8'hA5, 4'b1010, 0);
        run("srl",    4'b0101, 8'hA5, 8'h02, 1'b1, 1'b0, 8'h29, 4'b0000, 0);
        run("xor",    4'b0100, 8'hA5, 8'hA5, 1'b1, 1'b0, 8'h00, 4'b0100, 0);
        run("sub3",   4'b0001, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 4'b0110, 0);

`ifdef SEQ_ALU_DIV_EN
        run("udiv",   4'b1010, 8'd100, 8'd7, 1'b1, 1'b0, 8'd14, 4'b0010, 8);
        run("urem",   4'b1011, 8'd100, 8'd7, 1'b1, 1'b0, 8'd2,  4'b0010, 8);
        run("udiv0",  4'b1010, 8'h55, 8'h00, 1'b1, 1'b0, 8'hFF, 4'b1011, 8);
        run("urem0",  4'b1011, 8'h55, 8'h00, 1'b0, 1'b0, 8'h55, 4'b1011, 8);
        run("illegal", 4'b1100, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 4'b1011, 0);
`else
        run("udiv_off", 4'b1010, 8'd100, 8'd7, 1'b1, 1'b0, 8'h00, 4'b0110, 0);
        run("urem_off", 4'b1011, 8'd100, 8'd7, 1'b1, 1'b0, 8'h00, 4'b0110, 0);
        run("illegal",  4'b1100, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 4'b0110, 0);
`endif

        // Reset during the 4th RUN cycle of a multiply
        run("pre_rst", 4'b0000, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 4'b1001, 0);
        alu_ctl   = 4'b1000;
        op_a      = 8'd15;
        op_b      = 8'd17;
        set_flags = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_busy", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy",   {15'd0, busy}, 16'd0);
        check("abort_done",   {15'd0, done}, 16'd0);
        check("abort_result", {8'h00, result}, 16'h0000);
        check("abort_flags",  {12'h000, flags}, 16'h0000);
        late = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) late = 1'b1;
        end
        check("abort_no_done", {15'd0, late}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Keeps the 1-cycle logic, arithmetic and shift operations, with a registered result.
- Adds iterative unsigned multiply (low and high word) and optional unsigned divide/remainder behind a start/busy/done handshake.
- Holds NZCV in an internal flag register; sits in the execute stage of the multi-cycle core, where the controller stalls on busy.

Parameters:
- N, 32, operand/result width; legal range 4..64.
- SW, $clog2(N), shift-amount width; shifts use b[SW-1:0] only.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  launch op; sampled only when busy=0
- a  in  N  operand A; latched on accepted start
- b  in  N  operand B; latched on accepted start
- ALUControl  in  4  opcode; latched on accepted start
- set_flags  in  1  update NZCV at completion; latched on accepted start
- busy  out  1  iterative op in progress
- done  out  1  one-cycle completion pulse
- result  out  N  registered result; held until the next done
- Z, N, V, C  out  1 each  registered flag outputs

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - On reset: state=IDLE, busy=0, done=0, result=0, Z=N=V=C=0.
- Opcodes:
  - 0000 ADD, 0001 SUB (a+~b+1), 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SRL, 0110 SLL, 0111 SRA.
  - 1000 MUL (low N bits), 1001 UMULH (high N bits of the 2N product).
  - 1010 UDIV, 1011 UREM.
  - 1100-1111 illegal.
- States: IDLE, RUN, DONE.
  - start is accepted in IDLE or DONE (busy=0); start is ignored in RUN.
  - Single-cycle op or illegal op: accepted start -> DONE.
    - result and done valid in the cycle after the start edge (latency 1); busy stays 0.
  - Iterative op: accepted start -> RUN with counter=N.
    - busy=1 for exactly N cycles, then -> DONE with done=1 (done is N+1 clocks after the start edge).
  - DONE lasts 1 cycle, then -> IDLE, unless a new start is accepted in that cycle (back-to-back allowed).
- MUL/UMULH:
  - Shift-add over 2N-bit accumulator, one multiplier bit per cycle, unsigned.
- UDIV/UREM:
  - Restoring division, one quotient bit per cycle.
  - Divide by zero still takes N cycles: quotient=all ones, remainder=a, V=1.
- Flags: written only at done, and only if the latched set_flags=1.
  - ADD/SUB: Z, N from result; C=carry out (SUB: C=1 means no borrow); V=signed overflow.
  - AND/OR/XOR: Z, N updated; C, V unchanged.
  - Shifts: Z, N updated; C=last bit shifted out; C unchanged if amount=0; V unchanged.
  - MUL/UMULH/UDIV/UREM: Z, N updated; C unchanged; V unchanged except divide by zero (V=1).
  - Illegal op: result=0; flags unchanged even if set_flags=1.
- Shifts: amount = b[SW-1:0]; amount 0 passes a through.
- Reset mid-operation: RUN aborts immediately; no done pulse; result and flags go to reset values.
- Operand or ALUControl changes while busy have no effect.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined: UDIV/UREM implemented as above.
- Undefined: divider hardware omitted; 1010/1011 behave as illegal ops (1-cycle done, result=0, flags unchanged).

Test Plan (N=8):
- ADD 8'h7F+8'h01, set_flags=1 -> done next cycle, result=8'h80, N=1 Z=0 C=0 V=1, busy never high.
- SUB 8'h05-8'h05, set_flags=1, then AND 8'hF0&8'h0F with set_flags=0 -> result 8'h00 Z=1 C=1; second op result 8'h00, flags still Z=1 C=1.
- MUL 15*17 -> busy 8 cycles, done at clock 9, result=8'hFF; UMULH 200*200 -> result=8'h9C; start pulsed while busy ignored.
- SRA 8'h90 by b=8'h03 -> result=8'hF2, C=0; SLL 8'h81 by 1 -> result=8'h02, C=1.
- With SEQ_ALU_DIV_EN: UDIV 100/7 -> 8'd14; UREM -> 8'd2; UDIV 8'h55/0 -> 8'hFF, V=1. Without the macro: UDIV -> 1-cycle done, result 0, flags unchanged.
- Reset asserted at 4th RUN cycle of MUL -> next cycle busy=0, done=0, result=0, flags=0; no later done pulse.
